// File: rtl/clk_div_multi.sv
// Multi-channel programmable slow-clock generator: per-channel divisor, enable and
// square/pulse mode, with shadowed glitch-free reconfiguration and a global phase restart.
module clk_div_multi #(
  parameter int NUM_CH  = 4,
  parameter int CNT_W   = 20,
  parameter int DEF_DIV = 312_500,
  parameter int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              wr_en,
  input  logic [CH_W-1:0]   wr_ch,
  input  logic [CNT_W-1:0]  wr_div,
  input  logic              wr_mode,
  input  logic [NUM_CH-1:0] ch_en,
  input  logic              sync_rst,
  output logic [NUM_CH-1:0] clk_out,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] pend
);

  localparam logic [CNT_W-1:0] DEF_DIV_C = CNT_W'(DEF_DIV);
  localparam logic [CNT_W-1:0] ONE_C     = CNT_W'(1'b1);

  logic [NUM_CH-1:0][CNT_W-1:0] cnt_r, cnt_s;
  logic [NUM_CH-1:0][CNT_W-1:0] div_r, div_s;
  logic [NUM_CH-1:0][CNT_W-1:0] sh_div_r, sh_div_s;
  logic [NUM_CH-1:0]            mode_r, mode_s;
  logic [NUM_CH-1:0]            sh_mode_r, sh_mode_s;
  logic [NUM_CH-1:0]            tog_r, tog_s;
  logic [NUM_CH-1:0]            tick_r, tick_s;
  logic [NUM_CH-1:0]            pend_r, pend_s;
  logic [NUM_CH-1:0]            clk_out_r, clk_out_s;
  logic [NUM_CH-1:0]            wr_hit_s;
  logic [NUM_CH-1:0]            wrap_s;
  logic [NUM_CH-1:0]            apply_s;

  // Decode the write target and the per-channel wrap / apply conditions.
  // An out-of-range wr_ch matches no channel, so such writes fall away naturally.
  always_comb begin
    wr_hit_s = '0;
    wrap_s   = '0;
    apply_s  = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      wr_hit_s[i] = wr_en && (int'(wr_ch) == i);
      // >= rather than == keeps the counter bounded even if div shrank while held
      wrap_s[i]   = ch_en[i] && (cnt_r[i] >= div_r[i]);
      apply_s[i]  = sync_rst || !ch_en[i] || wrap_s[i];
    end
  end

  // Next-state logic for every channel: counter, toggle, tick, config shadow.
  always_comb begin
    cnt_s     = cnt_r;
    div_s     = div_r;
    sh_div_s  = sh_div_r;
    mode_s    = mode_r;
    sh_mode_s = sh_mode_r;
    tog_s     = tog_r;
    tick_s    = tick_r;
    pend_s    = pend_r;
    clk_out_s = clk_out_r;
    for (int i = 0; i < NUM_CH; i++) begin
      if (sync_rst) begin
        cnt_s[i]  = '0;
        tog_s[i]  = 1'b0;
        tick_s[i] = 1'b0;
      end else if (!ch_en[i]) begin
        cnt_s[i]  = cnt_r[i];
        tog_s[i]  = tog_r[i];
        tick_s[i] = 1'b0;
      end else if (wrap_s[i]) begin
        cnt_s[i]  = '0;
        tog_s[i]  = ~tog_r[i];
        tick_s[i] = 1'b1;
      end else begin
        cnt_s[i]  = cnt_r[i] + ONE_C;
        tog_s[i]  = tog_r[i];
        tick_s[i] = 1'b0;
      end

      // Config only changes at a point where cnt is 0 or frozen, so no runt edges.
      if (apply_s[i]) begin
        pend_s[i] = 1'b0;
        if (wr_hit_s[i]) begin
          div_s[i]     = wr_div;
          mode_s[i]    = wr_mode;
          sh_div_s[i]  = wr_div;
          sh_mode_s[i] = wr_mode;
        end else if (pend_r[i]) begin
          div_s[i]  = sh_div_r[i];
          mode_s[i] = sh_mode_r[i];
        end else begin
          div_s[i]  = div_r[i];
          mode_s[i] = mode_r[i];
        end
      end else begin
        div_s[i]  = div_r[i];
        mode_s[i] = mode_r[i];
        if (wr_hit_s[i]) begin
          sh_div_s[i]  = wr_div;
          sh_mode_s[i] = wr_mode;
          pend_s[i]    = 1'b1;
        end else begin
          sh_div_s[i]  = sh_div_r[i];
          sh_mode_s[i] = sh_mode_r[i];
          pend_s[i]    = pend_r[i];
        end
      end

      clk_out_s[i] = mode_s[i] ? tick_s[i] : tog_s[i];
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt_r     <= '0;
      div_r     <= {NUM_CH{DEF_DIV_C}};
      sh_div_r  <= {NUM_CH{DEF_DIV_C}};
      mode_r    <= '0;
      sh_mode_r <= '0;
      tog_r     <= '0;
      tick_r    <= '0;
      pend_r    <= '0;
      clk_out_r <= '0;
    end else begin
      cnt_r     <= cnt_s;
      div_r     <= div_s;
      sh_div_r  <= sh_div_s;
      mode_r    <= mode_s;
      sh_mode_r <= sh_mode_s;
      tog_r     <= tog_s;
      tick_r    <= tick_s;
      pend_r    <= pend_s;
      clk_out_r <= clk_out_s;
    end
  end

  assign clk_out = clk_out_r;
  assign tick    = tick_r;
  assign pend    = pend_r;

endmodule

// File: tb/tb_clk_div_multi.sv
// Scoreboard bench for clk_div_multi: stimulus queues hand-computed expectations
// keyed by cycle, an independent monitor compares them against the DUT outputs.
module tb_clk_div_multi;

  localparam int NUM_CH  = 5;
  localparam int CNT_W   = 20;
  localparam int DEF_DIV = 20;
  localparam int CH_W    = 3;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              wr_en;
  logic [CH_W-1:0]   wr_ch;
  logic [CNT_W-1:0]  wr_div;
  logic              wr_mode;
  logic [NUM_CH-1:0] ch_en;
  logic              sync_rst;
  logic [NUM_CH-1:0] clk_out;
  logic [NUM_CH-1:0] tick;
  logic [NUM_CH-1:0] pend;

  clk_div_multi #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .DEF_DIV(DEF_DIV)) dut (
    .clk(clk), .reset_n(reset_n), .wr_en(wr_en), .wr_ch(wr_ch), .wr_div(wr_div),
    .wr_mode(wr_mode), .ch_en(ch_en), .sync_rst(sync_rst),
    .clk_out(clk_out), .tick(tick), .pend(pend)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // sig: 0 clk_out bit, 1 tick bit, 2 pend bit, 3 clk_out vec, 4 tick vec, 5 pend vec
  typedef struct {
    int    due;
    int    sig;
    int    ch;
    int    val;
    string name;
  } exp_t;

  exp_t sb[$];
  int checks   = 0;
  int failures = 0;

  task automatic exp_at(input int due, input int sig, input int ch, input int val, input string name);
    exp_t e;
    e.due = due; e.sig = sig; e.ch = ch; e.val = val; e.name = name;
    sb.push_back(e);
  endtask

  function automatic int get_act(input int sig, input int ch);
    case (sig)
      0: return int'(clk_out[ch]);
      1: return int'(tick[ch]);
      2: return int'(pend[ch]);
      3: return int'(clk_out);
      4: return int'(tick);
      5: return int'(pend);
      default: return -1;
    endcase
  endfunction

  task automatic wait_until(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  // monitor: compare every expectation due at the current cycle
  initial begin
    forever begin
      @(negedge clk);
      for (int i = sb.size() - 1; i >= 0; i--) begin
        if (sb[i].due == cyc) begin
          int act;
          act = get_act(sb[i].sig, sb[i].ch);
          checks++;
          if (act != sb[i].val) begin
            failures++;
            $display("FAIL %s cycle=%0d got=%0d expected=%0d", sb[i].name, cyc, act, sb[i].val);
          end
          sb.delete(i);
        end
      end
    end
  end

  int c0, c, s, n, s2, a, b, s3;

  initial begin
    reset_n = 1'b0; wr_en = 1'b0; wr_ch = '0; wr_div = '0; wr_mode = 1'b0;
    sync_rst = 1'b0; ch_en = 5'b11111;
    repeat (3) @(negedge clk);
    checks++;
    if (clk_out !== 5'b00000) begin
      failures++;
      $display("FAIL in_rst_clk_out got=%b", clk_out);
    end
    checks++;
    if (tick !== 5'b00000) begin
      failures++;
      $display("FAIL in_rst_tick got=%b", tick);
    end
    checks++;
    if (pend !== 5'b00000) begin
      failures++;
      $display("FAIL in_rst_pend got=%b", pend);
    end
    exp_at(cyc + 1, 3, 0, 0, "rst_clk_out");
    exp_at(cyc + 1, 4, 0, 0, "rst_tick");
    exp_at(cyc + 1, 5, 0, 0, "rst_pend");
    @(negedge clk);

    // reset release, default divisor 20
    reset_n = 1'b1;
    c0 = cyc;
    exp_at(c0 + 1,  5, 0, 0, "pend_after_rst");
    exp_at(c0 + 20, 1, 0, 0, "tick0_pre");
    exp_at(c0 + 20, 0, 0, 0, "clk0_pre");
    exp_at(c0 + 21, 1, 0, 1, "tick0_first");
    exp_at(c0 + 21, 0, 0, 1, "clk0_rise");
    exp_at(c0 + 22, 1, 0, 0, "tick0_one_cycle");
    exp_at(c0 + 41, 0, 0, 1, "clk0_high_end");
    exp_at(c0 + 42, 0, 0, 0, "clk0_fall");
    exp_at(c0 + 42, 1, 0, 1, "tick0_second");

    // write ch1 div=3, then sync_rst applies the pending shadow
    wait_until(c0 + 45);
    c = cyc;
    wr_en = 1'b1; wr_ch = 3'd1; wr_div = 20'd3; wr_mode = 1'b0;
    exp_at(c + 1, 2, 1, 1, "pend1_set");
    @(negedge clk);
    wr_en = 1'b0; sync_rst = 1'b1;
    s = c + 2;
    exp_at(s,      5, 0, 0, "sync_pend_clr");
    exp_at(s,      3, 0, 0, "sync_clk_out");
    exp_at(s,      4, 0, 0, "sync_tick");
    exp_at(s + 3,  1, 1, 0, "tick1_pre");
    exp_at(s + 4,  1, 1, 1, "tick1_a");
    exp_at(s + 5,  1, 1, 0, "tick1_gap");
    exp_at(s + 8,  1, 1, 1, "tick1_b");
    exp_at(s + 4,  0, 1, 1, "clk1_rise");
    exp_at(s + 7,  0, 1, 1, "clk1_high4");
    exp_at(s + 8,  0, 1, 0, "clk1_fall");
    exp_at(s + 11, 0, 1, 0, "clk1_low4");
    exp_at(s + 12, 0, 1, 1, "clk1_rise2");
    exp_at(s + 20, 0, 0, 0, "clk0_after_sync_pre");
    exp_at(s + 21, 1, 0, 1, "tick0_after_sync");
    exp_at(s + 21, 1, 2, 1, "tick2_aligned");
    exp_at(s + 21, 0, 0, 1, "clk0_after_sync");
    @(negedge clk);
    sync_rst = 1'b0;

    // sync_rst with coincident write ch2 div=4, then write div=1 at cnt=2
    wait_until(s + 24);
    n = cyc;
    s2 = n + 1;
    sync_rst = 1'b1; wr_en = 1'b1; wr_ch = 3'd2; wr_div = 20'd4; wr_mode = 1'b0;
    exp_at(s2,     2, 2, 0, "pend2_coincident");
    exp_at(s2,     1, 2, 0, "tick2_sync");
    exp_at(s2 + 2, 2, 2, 0, "pend2_before_wr");
    exp_at(s2 + 3, 2, 2, 1, "pend2_set");
    exp_at(s2 + 4, 2, 2, 1, "pend2_hold");
    exp_at(s2 + 4, 0, 2, 0, "clk2_old_half");
    exp_at(s2 + 5, 2, 2, 0, "pend2_applied");
    exp_at(s2 + 5, 0, 2, 1, "clk2_rise");
    exp_at(s2 + 5, 1, 2, 1, "tick2_wrap_old");
    exp_at(s2 + 6, 0, 2, 1, "clk2_new_high");
    exp_at(s2 + 6, 1, 2, 0, "tick2_new_gap");
    exp_at(s2 + 7, 0, 2, 0, "clk2_new_fall");
    exp_at(s2 + 7, 1, 2, 1, "tick2_new");
    exp_at(s2 + 8, 0, 2, 0, "clk2_new_low");
    exp_at(s2 + 9, 0, 2, 1, "clk2_new_rise");
    exp_at(s2 + 4, 1, 1, 1, "tick1_after_sync2");
    @(negedge clk);
    sync_rst = 1'b0; wr_en = 1'b0;
    wait_until(s2 + 2);
    wr_en = 1'b1; wr_ch = 3'd2; wr_div = 20'd1; wr_mode = 1'b0;
    @(negedge clk);
    wr_en = 1'b0;

    // ch3: write while disabled (div=0 pulse), re-enable, then div=2
    wait_until(s2 + 12);
    a = cyc;
    ch_en[3] = 1'b0;
    wr_en = 1'b1; wr_ch = 3'd3; wr_div = 20'd0; wr_mode = 1'b1;
    exp_at(a + 1, 2, 3, 0, "pend3_disabled_apply");
    exp_at(a + 1, 0, 3, 0, "clk3_disabled");
    exp_at(a + 2, 0, 3, 1, "clk3_div0_a");
    exp_at(a + 3, 1, 3, 1, "tick3_div0");
    exp_at(a + 4, 0, 3, 1, "clk3_div0_b");
    exp_at(a + 5, 1, 3, 1, "tick3_wrap_apply");
    exp_at(a + 5, 2, 3, 0, "pend3_wrap_apply");
    exp_at(a + 6, 0, 3, 0, "clk3_div2_lo1");
    exp_at(a + 7, 0, 3, 0, "clk3_div2_lo2");
    exp_at(a + 8, 0, 3, 1, "clk3_div2_hi");
    exp_at(a + 9, 0, 3, 0, "clk3_div2_lo3");
    @(negedge clk);
    wr_en = 1'b0; ch_en[3] = 1'b1;
    wait_until(a + 4);
    wr_en = 1'b1; wr_ch = 3'd3; wr_div = 20'd2; wr_mode = 1'b1;
    @(negedge clk);
    wr_en = 1'b0;

    // ch0 frozen at cnt=10 for 50 cycles; out-of-range write; reset mid-count
    wait_until(a + 12);
    b = cyc;
    s3 = b + 1;
    sync_rst = 1'b1;
    exp_at(s3 + 21,  1, 0, 0, "tick0_frozen");
    exp_at(s3 + 21,  1, 4, 1, "tick4_running");
    exp_at(s3 + 40,  0, 0, 0, "clk0_frozen");
    exp_at(s3 + 70,  1, 0, 0, "tick0_resume_pre");
    exp_at(s3 + 71,  1, 0, 1, "tick0_resume_wrap");
    exp_at(s3 + 71,  0, 0, 1, "clk0_resume_rise");
    exp_at(s3 + 76,  5, 0, 0, "pend_bad_ch");
    exp_at(s3 + 92,  1, 0, 1, "tick0_div_kept_a");
    exp_at(s3 + 113, 1, 0, 1, "tick0_div_kept_b");
    exp_at(s3 + 115, 0, 0, 1, "clk0_before_rst");
    exp_at(s3 + 115, 2, 4, 1, "pend4_before_rst");
    exp_at(s3 + 116, 3, 0, 0, "midrst_clk_out");
    exp_at(s3 + 116, 4, 0, 0, "midrst_tick");
    exp_at(s3 + 116, 5, 0, 0, "midrst_pend");
    exp_at(s3 + 117, 5, 0, 0, "pend_after_midrst");
    exp_at(s3 + 136, 1, 0, 0, "tick0_rel_pre");
    exp_at(s3 + 137, 1, 0, 1, "tick0_rel_default");
    exp_at(s3 + 137, 1, 4, 1, "tick4_rel_default");
    @(negedge clk);
    sync_rst = 1'b0;
    wait_until(s3 + 10);
    ch_en[0] = 1'b0;
    wait_until(s3 + 60);
    ch_en[0] = 1'b1;
    wait_until(s3 + 75);
    wr_en = 1'b1; wr_ch = 3'd7; wr_div = 20'd1; wr_mode = 1'b1;
    @(negedge clk);
    wr_en = 1'b0;
    wait_until(s3 + 114);
    wr_en = 1'b1; wr_ch = 3'd4; wr_div = 20'd5; wr_mode = 1'b0;
    @(negedge clk);
    wr_en = 1'b0; reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;

    wait_until(s3 + 142);
    foreach (sb[i]) begin
      failures++;
      $display("FAIL %s expired due=%0d", sb[i].name, sb[i].due);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
